// File: rtl/bk_slot_seq_if.sv
// bk_slot_seq_if: sector request/acknowledge bus between the slot sequencer and hps_io.
interface bk_slot_seq_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  modport master(output sd_lba, sd_rd, sd_wr, input sd_ack);
  modport slave(input sd_lba, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/bk_slot_seq.sv
// bk_slot_seq: turns load/save requests into a burst of sector transfers at a slot-derived LBA.
// Dirty-tracked autosave is built only when BK_AUTOSAVE_EN is defined.
module bk_slot_seq #(
  parameter int          SLOT_BITS = 2,
  parameter int          SECT_BITS = 6,
  parameter logic [31:0] BASE_LBA  = 32'd0,
  parameter int          TMO_BITS  = 24,
  parameter int          AS_BITS   = 26
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 enable,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 dirty,
  bk_slot_seq_if.master        sd,
  output logic [SECT_BITS-1:0] sect_idx,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 error
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t st, st_n;
  logic ld_q, ld_qq, sv_q, sv_qq, ack_q, ack_qq, as_go;
  logic ld_e, sv_e, ack_r, ack_f, last, start, tmo_hit, fin, nxt;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SECT_BITS-1:0] sect_nx;
  logic [TMO_BITS-1:0]  tmo, tmo_nx;
  always_comb begin
    ld_e    = ld_q & ~ld_qq;
    sv_e    = sv_q & ~sv_qq;
    ack_r   = ack_q & ~ack_qq;
    ack_f   = ~ack_q & ack_qq;
    start   = (st == IDLE) & (ld_e | sv_e | as_go);
    tmo_nx  = tmo + 1'b1;
    tmo_hit = (st == REQ) & ~ack_r & (&tmo_nx);
    last    = &sect_idx;
    sect_nx = sect_idx + 1'b1;
    fin     = (st == XFER) & ack_f & last;
    nxt     = (st == XFER) & ack_f & ~last;
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = start ? REQ : IDLE;
      REQ:     st_n = ack_r ? XFER : tmo_hit ? IDLE : REQ;
      XFER:    st_n = ack_f ? (last ? IDLE : REQ) : XFER;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      {ld_q, ld_qq, sv_q, sv_qq, ack_q, ack_qq} <= '0;
      {sd.sd_rd, sd.sd_wr, busy, loading, done, error} <= '0;
      sd.sd_lba <= '0;
      sect_idx  <= '0;
      slot_q    <= '0;
      tmo       <= '0;
    end else begin
      ld_q   <= load_req & enable;
      ld_qq  <= ld_q;
      sv_q   <= save_req & enable;
      sv_qq  <= sv_q;
      ack_q  <= sd.sd_ack;
      ack_qq <= ack_q;
      done   <= fin;
      if (start) begin
        slot_q    <= slot;
        sect_idx  <= '0;
        busy      <= 1'b1;
        loading   <= ld_e;
        sd.sd_rd  <= ld_e;
        sd.sd_wr  <= ~ld_e;
        error     <= 1'b0;
        tmo       <= '0;
        sd.sd_lba <= BASE_LBA + 32'({slot, {SECT_BITS{1'b0}}});
      end else if (st == REQ) begin
        if (ack_r) {sd.sd_rd, sd.sd_wr} <= '0;
        else if (tmo_hit) begin
          {sd.sd_rd, sd.sd_wr, busy, loading} <= '0;
          error <= 1'b1;
        end else tmo <= tmo_nx;
      end else if (fin) {busy, loading} <= '0;
      else if (nxt) begin
        sect_idx  <= sect_nx;
        sd.sd_rd  <= loading;
        sd.sd_wr  <= ~loading;
        tmo       <= '0;
        sd.sd_lba <= BASE_LBA + 32'({slot_q, sect_nx});
      end
    end
  end
`ifdef BK_AUTOSAVE_EN
  logic dflag;
  logic [AS_BITS-1:0] qcnt;
  assign as_go = dflag & enable & (&qcnt);
  // a fresh write outranks a clear in the same cycle
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dflag <= 1'b0;
      qcnt  <= '0;
    end else if (dirty) begin
      dflag <= 1'b1;
      qcnt  <= '0;
    end else begin
      if ((start & ~ld_e) | (fin & loading)) dflag <= 1'b0;
      if (!(&qcnt)) qcnt <= qcnt + 1'b1;
    end
  end
`else
  logic unused_dirty;
  assign as_go        = 1'b0;
  assign unused_dirty = dirty | (AS_BITS == 0);
`endif
endmodule

// File: tb/tb_bk_slot_seq.sv
// tb_bk_slot_seq: randomized bench for bk_slot_seq with an hps_io ack model and a per-transfer LBA model.
module tb_bk_slot_seq;
  localparam int          SB   = 2;
  localparam int          XB   = 6;
  localparam int          NS   = 64;
  localparam logic [31:0] BASE = 32'd1000;
  logic clk_sys = 0, RESET_n = 0, enable = 0, load_req = 0, save_req = 0, dirty = 0;
  logic [SB-1:0] slot = '0;
  logic [XB-1:0] sect_idx;
  logic busy, loading, done, error;
  int pass_n = 0, tot_n = 0;
  bit ack_on = 1;
  int ack_len = 10;
  logic [31:0] lba_q[$];
  bit rd_q[$];
  logic [XB-1:0] idx_q[$];
  int n_done, n_done_busy, cyc_ld, cyc_sv, req_len, n_both;
  bit req_prev = 0;

  bk_slot_seq_if sd();
  bk_slot_seq #(.SLOT_BITS(SB), .SECT_BITS(XB), .BASE_LBA(BASE), .TMO_BITS(4), .AS_BITS(8)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .enable(enable), .load_req(load_req),
    .save_req(save_req), .slot(slot), .dirty(dirty), .sd(sd.master), .sect_idx(sect_idx),
    .busy(busy), .loading(loading), .done(done), .error(error));

  always #5 clk_sys = ~clk_sys;

  initial begin
    sd.sd_ack = 0;
    forever begin
      @(negedge clk_sys);
      if (ack_on && RESET_n && (sd.sd_rd || sd.sd_wr) && !sd.sd_ack) begin
        repeat ($urandom_range(1, 8)) @(negedge clk_sys);
        sd.sd_ack = 1;
        repeat (ack_len) @(negedge clk_sys);
        sd.sd_ack = 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if ((sd.sd_rd || sd.sd_wr) && !req_prev) begin
      lba_q.push_back(sd.sd_lba);
      rd_q.push_back(sd.sd_rd);
      idx_q.push_back(sect_idx);
      req_len = 0;
    end
    if (sd.sd_rd || sd.sd_wr) req_len++;
    if (sd.sd_rd && sd.sd_wr) n_both++;
    if (done) n_done++;
    if (done && busy) n_done_busy++;
    if (busy && loading) cyc_ld++;
    if (busy && !loading) cyc_sv++;
    req_prev = sd.sd_rd || sd.sd_wr;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    lba_q.delete(); rd_q.delete(); idx_q.delete();
    n_done = 0; n_done_busy = 0; cyc_ld = 0; cyc_sv = 0; req_len = 0; n_both = 0;
  endtask

  task automatic kick(input bit ld, input bit sv, input logic [SB-1:0] s);
    @(negedge clk_sys);
    slot = s; load_req = ld; save_req = sv;
  endtask

  task automatic rel();
    @(negedge clk_sys);
    load_req = 0; save_req = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    @(negedge clk_sys);
    while (busy && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    ok = !busy;
    #1;
  endtask

  // expected burst: sector i of slot s sits at BASE + s*2^SECT_BITS + i, modulo 2^32
  function automatic int model_bad(input bit ld, input int s);
    int b = 0;
    logic [31:0] e;
    for (int i = 0; i < lba_q.size(); i++) begin
      e = BASE + 32'(s * NS + i);
      if (lba_q[i] !== e || rd_q[i] !== ld || idx_q[i] !== XB'(i)) b++;
    end
    return b;
  endfunction

  task automatic test_reset();
    RESET_n = 0; enable = 0;
    repeat (3) @(negedge clk_sys);
    tot_n++; if ({sd.sd_rd, sd.sd_wr, busy, loading, done, error} !== 6'b0) $display("FAIL reset_flags got %b want 000000", {sd.sd_rd, sd.sd_wr, busy, loading, done, error}); else pass_n++;
    tot_n++; if (sd.sd_lba !== 32'd0) $display("FAIL reset_lba got %0d want 0", sd.sd_lba); else pass_n++;
    tot_n++; if (sect_idx !== '0) $display("FAIL reset_sect got %0d want 0", sect_idx); else pass_n++;
    RESET_n = 1; enable = 1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_save();
    bit ok;
    clear_log(); ack_len = 10;
    kick(0, 1, 2);
    @(negedge clk_sys);
    tot_n++; if (busy !== 1'b0) $display("FAIL save_lat0 busy got %b want 0", busy); else pass_n++;
    @(negedge clk_sys);
    tot_n++; if ({busy, sd.sd_wr, sd.sd_rd} !== 3'b110 || sd.sd_lba !== BASE + 128) $display("FAIL save_lat1 got busy/wr/rd %b lba %0d want 110 lba %0d", {busy, sd.sd_wr, sd.sd_rd}, sd.sd_lba, BASE + 128); else pass_n++;
    wait_idle(6000, ok);
    tot_n++; if (!ok) $display("FAIL save_finish busy got 1 want 0"); else pass_n++;
    tot_n++; if (lba_q.size() !== NS) $display("FAIL save_count got %0d want %0d", lba_q.size(), NS); else pass_n++;
    tot_n++; if (model_bad(0, 2) !== 0) $display("FAIL save_lba bad sectors got %0d want 0", model_bad(0, 2)); else pass_n++;
    tot_n++; if (cyc_ld !== 0) $display("FAIL save_loading cycles got %0d want 0", cyc_ld); else pass_n++;
    tot_n++; if (n_done !== 1 || n_done_busy !== 0) $display("FAIL save_done got %0d (busy %0d) want 1 (0)", n_done, n_done_busy); else pass_n++;
    @(negedge clk_sys);
    tot_n++; if ({done, busy, error} !== 3'b0) $display("FAIL save_after got done/busy/err %b want 000", {done, busy, error}); else pass_n++;
    rel();
  endtask

  task automatic test_load_wins();
    bit ok;
    clear_log(); ack_len = 10;
    kick(1, 1, 1);
    repeat (2) @(negedge clk_sys);
    tot_n++; if ({sd.sd_rd, sd.sd_wr, loading} !== 3'b101 || sd.sd_lba !== 32'd1064) $display("FAIL both_first got rd/wr/ld %b lba %0d want 101 lba 1064", {sd.sd_rd, sd.sd_wr, loading}, sd.sd_lba); else pass_n++;
    wait_idle(6000, ok);
    tot_n++; if (!ok || lba_q.size() !== NS) $display("FAIL both_count got %0d want %0d", lba_q.size(), NS); else pass_n++;
    tot_n++; if (model_bad(1, 1) !== 0) $display("FAIL both_lba bad sectors got %0d want 0", model_bad(1, 1)); else pass_n++;
    tot_n++; if (cyc_sv !== 0 || n_done !== 1) $display("FAIL both_loading nonload cycles %0d done %0d want 0 and 1", cyc_sv, n_done); else pass_n++;
    repeat (40) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== NS || busy !== 1'b0) $display("FAIL both_no_retrigger got %0d requests busy %b want %0d 0", lba_q.size(), busy, NS); else pass_n++;
    rel();
  endtask

  task automatic test_busy_ignore();
    bit ok;
    clear_log(); ack_len = 6;
    kick(0, 1, 3);
    repeat (100) @(negedge clk_sys);
    load_req = 1;
    repeat (100) @(negedge clk_sys);
    enable = 0;
    wait_idle(6000, ok);
    tot_n++; if (!ok || lba_q.size() !== NS) $display("FAIL busy_ign_count got %0d want %0d", lba_q.size(), NS); else pass_n++;
    tot_n++; if (model_bad(0, 3) !== 0 || n_done !== 1) $display("FAIL busy_ign_lba bad %0d done %0d want 0 1", model_bad(0, 3), n_done); else pass_n++;
    rel();
    enable = 1;
    repeat (30) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== NS || busy !== 1'b0) $display("FAIL busy_ign_queued got %0d requests want %0d", lba_q.size(), NS); else pass_n++;
  endtask

  task automatic test_random();
    bit ok, ld;
    int s;
    for (int t = 0; t < 5; t++) begin
      clear_log();
      ld = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      ack_len = $urandom_range(1, 12);
      kick(ld, !ld, SB'(s));
      repeat (2) @(negedge clk_sys);
      wait_idle(6000, ok);
      tot_n++; if (!ok || lba_q.size() !== NS) $display("FAIL rand%0d_count got %0d want %0d", t, lba_q.size(), NS); else pass_n++;
      tot_n++; if (model_bad(ld, s) !== 0 || n_both !== 0) $display("FAIL rand%0d_lba bad %0d both %0d want 0 0", t, model_bad(ld, s), n_both); else pass_n++;
      tot_n++; if (n_done !== 1 || (ld ? cyc_sv : cyc_ld) !== 0) $display("FAIL rand%0d_done done %0d wrongdir %0d want 1 0", t, n_done, ld ? cyc_sv : cyc_ld); else pass_n++;
      rel();
      repeat (3) @(negedge clk_sys);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log(); ack_on = 0;
    kick(0, 1, 0);
    repeat (2) @(negedge clk_sys);
    wait_idle(100, ok);
    tot_n++; if (!ok || req_len !== 15) $display("FAIL tmo_len got %0d cycles want 15", req_len); else pass_n++;
    tot_n++; if ({error, busy, loading} !== 3'b100 || n_done !== 0) $display("FAIL tmo_flags got err/busy/ld %b done %0d want 100 0", {error, busy, loading}, n_done); else pass_n++;
    rel();
    ack_on = 1; clear_log();
    kick(1, 0, 2);
    repeat (2) @(negedge clk_sys);
    tot_n++; if ({busy, error} !== 2'b10) $display("FAIL tmo_clear got busy/err %b want 10", {busy, error}); else pass_n++;
    wait_idle(6000, ok);
    tot_n++; if (!ok || lba_q.size() !== NS || model_bad(1, 2) !== 0 || error !== 1'b0) $display("FAIL tmo_recover got %0d sectors bad %0d err %b want %0d 0 0", lba_q.size(), model_bad(1, 2), error, NS); else pass_n++;
    rel();
  endtask

  task automatic test_async_reset();
    bit ok;
    int k = 0;
    clear_log(); ack_len = 5;
    kick(1, 0, 3);
    while (sect_idx !== XB'(5) && k < 2000) begin
      @(negedge clk_sys);
      k++;
    end
    tot_n++; if (sect_idx !== XB'(5)) $display("FAIL arst_reach got %0d want 5", sect_idx); else pass_n++;
    #2 RESET_n = 0;
    #1;
    tot_n++; if ({sd.sd_rd, sd.sd_wr, busy, loading, done, error} !== 6'b0 || sd.sd_lba !== 32'd0 || sect_idx !== '0) $display("FAIL arst_outputs got %b lba %0d sect %0d want 000000 0 0", {sd.sd_rd, sd.sd_wr, busy, loading, done, error}, sd.sd_lba, sect_idx); else pass_n++;
    load_req = 0;
    repeat (30) @(negedge clk_sys);
    RESET_n = 1;
    clear_log();
    repeat (2) @(negedge clk_sys);
    kick(0, 1, 0);
    repeat (2) @(negedge clk_sys);
    tot_n++; if (sd.sd_wr !== 1'b1 || sect_idx !== '0 || sd.sd_lba !== BASE) $display("FAIL arst_restart got wr %b sect %0d lba %0d want 1 0 %0d", sd.sd_wr, sect_idx, sd.sd_lba, BASE); else pass_n++;
    wait_idle(6000, ok);
    tot_n++; if (!ok || lba_q.size() !== NS || model_bad(0, 0) !== 0) $display("FAIL arst_burst got %0d sectors bad %0d want %0d 0", lba_q.size(), model_bad(0, 0), NS); else pass_n++;
    rel();
  endtask

`ifdef BK_AUTOSAVE_EN
  task automatic test_autosave();
    bit ok;
    int k = 0;
    clear_log(); ack_len = 4; slot = 1; enable = 1;
    @(negedge clk_sys) dirty = 1;
    @(negedge clk_sys) dirty = 0;
    repeat (100) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== 0) $display("FAIL as_early got %0d requests want 0", lba_q.size()); else pass_n++;
    dirty = 1;
    @(negedge clk_sys) dirty = 0;
    while (!sd.sd_wr && k < 400) begin
      @(negedge clk_sys);
      k++;
    end
    tot_n++; if (k < 255 || k > 257) $display("FAIL as_delay got %0d cycles want 255..257", k); else pass_n++;
    tot_n++; if (sd.sd_lba !== BASE + 64) $display("FAIL as_lba got %0d want %0d", sd.sd_lba, BASE + 64); else pass_n++;
    wait_idle(6000, ok);
    tot_n++; if (!ok || lba_q.size() !== NS || model_bad(0, 1) !== 0) $display("FAIL as_burst got %0d sectors bad %0d want %0d 0", lba_q.size(), model_bad(0, 1), NS); else pass_n++;
    repeat (300) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== NS) $display("FAIL as_cleared got %0d requests want %0d", lba_q.size(), NS); else pass_n++;
    clear_log(); enable = 0;
    @(negedge clk_sys) dirty = 1;
    @(negedge clk_sys) dirty = 0;
    repeat (400) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== 0 || busy !== 1'b0) $display("FAIL as_disabled got %0d requests want 0", lba_q.size()); else pass_n++;
    RESET_n = 0;
    @(negedge clk_sys) RESET_n = 1;
    enable = 1;
  endtask
`else
  task automatic test_autosave();
    clear_log(); enable = 1;
    @(negedge clk_sys) dirty = 1;
    @(negedge clk_sys) dirty = 0;
    repeat (400) @(negedge clk_sys);
    tot_n++; if (lba_q.size() !== 0 || busy !== 1'b0) $display("FAIL dirty_ignored got %0d requests want 0", lba_q.size()); else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
    test_save();
    test_load_wins();
    test_busy_ignore();
    test_random();
    test_timeout();
    test_async_reset();
    test_autosave();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
